radix4_mul_arbiter: RTL and testbench

Shares one Radix-4 16x16 multiplier between N_REQ requesters. Requesters are served round-robin. The block drives the multiplier start/operand interface and waits for its ready pulse. It returns the 32-bit product to the granted requester, and a watchdog aborts any operation whose ready pulse never arrives. It sits between client blocks and the multiplier top (start/busy/ready handshake).

---
 rtl/radix4_mul_arbiter_pkg.sv | 9 +
 rtl/radix4_mul_arbiter_rr_pick.sv | 26 ++
 rtl/radix4_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_radix4_mul_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/radix4_mul_arbiter_pkg.sv
// Shared types and default sizing for the radix-4 multiplier arbiter.
package radix4_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int OP_W_DEF    = 16;
  localparam int TIMEOUT_DEF = 32;
  localparam int ID_W        = $clog2(N_REQ_DEF);
endpackage

// File: rtl/radix4_mul_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  id
);
  int idx;

  // Scan from the farthest offset down so the closest set bit to ptr wins last.
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        any = 1'b1;
        id  = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/radix4_mul_arbiter.sv
// Round-robin sharing of one multiplier: grant, issue, wait for ready (with watchdog), deliver.
module radix4_mul_arbiter
  import radix4_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*OP_W-1:0] a_in,
  input  logic [N_REQ*OP_W-1:0] b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      res_valid,
  output logic [2*OP_W-1:0]     res_data,
  output logic                  res_err,
  output logic                  mul_start,
  output logic [OP_W-1:0]       mul_a,
  output logic [OP_W-1:0]       mul_b,
  input  logic                  mul_busy,
  input  logic                  mul_ready,
  input  logic [2*OP_W-1:0]     mul_out
);
  localparam int IW   = $clog2(N_REQ);
  localparam int TM_W = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       id_q, id_d;
  logic [TM_W-1:0]     timer_q, timer_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    res_valid_q, res_valid_d;
  logic [2*OP_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic                mul_start_q, mul_start_d;
  logic [OP_W-1:0]     mul_a_q, mul_a_d;
  logic [OP_W-1:0]     mul_b_q, mul_b_d;

  logic                pick_any;
  logic [IW-1:0]       pick_id;
  logic [OP_W-1:0]     sel_a, sel_b;

  rr_pick #(.N_REQ(N_REQ), .ID_W(IW)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .id  (pick_id)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == IW'(i)) begin
        sel_a = a_in[i*OP_W +: OP_W];
        sel_b = b_in[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    timer_d     = timer_q;
    gnt_d       = gnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    mul_start_d = mul_start_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any && !mul_busy) begin
          id_d        = pick_id;
          mul_a_d     = sel_a;
          mul_b_d     = sel_b;
          gnt_d       = N_REQ'(1) << pick_id;
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        gnt_d       = '0;
        mul_start_d = 1'b0;
        timer_d     = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // A real ready wins over a watchdog expiry landing on the same cycle.
        if (mul_ready) begin
          res_data_d  = mul_out;
          res_valid_d = N_REQ'(1) << id_q;
          res_err_d   = 1'b0;
          state_d     = DELIVER;
        end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
          res_data_d  = '0;
          res_valid_d = N_REQ'(1) << id_q;
          res_err_d   = 1'b1;
          state_d     = DELIVER;
        end else begin
          timer_d = timer_q + TM_W'(1);
        end
      end
      DELIVER: begin
        res_valid_d = '0;
        res_err_d   = 1'b0;
        rr_ptr_d    = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      timer_q     <= '0;
      gnt_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
endmodule

// File: tb/tb_radix4_mul_arbiter.sv
// Self-checking bench: vector table, corner-case sequences and random round-robin traffic.
module tb_radix4_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a_in, b_in;
  logic [N-1:0]    gnt, res_valid;
  logic [2*W-1:0]  res_data;
  logic            res_err, mul_start;
  logic [W-1:0]    mul_a, mul_b;
  logic            mul_busy, mul_ready;
  logic [2*W-1:0]  mul_out;

  int n_checks = 0;
  int n_fail   = 0;

  radix4_mul_arbiter #(.N_REQ(N), .OP_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_ready(mul_ready), .mul_out(mul_out)
  );

  always #5 clk = ~clk;

  // Multiplier model: ready pulse L cycles after the start cycle, busy while counting.
  int          m_cnt = 0;
  int          m_lat = 2;
  bit          m_noready = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_prod = '0;
  logic        busy_force, spur_ready;

  always @(posedge clk) begin
    m_ready <= 1'b0;
    if (mul_start) begin
      m_cnt  <= m_lat;
      m_prod <= {16'b0, mul_a} * {16'b0, mul_b};
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2 && !m_noready) m_ready <= 1'b1;
    end
  end

  assign mul_ready = m_ready | spur_ready;
  assign mul_busy  = busy_force | (m_cnt != 0);
  assign mul_out   = m_prod;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction; called at a negedge in IDLE. ek = cycle of res_valid counting E0's cycle as 0.
  task automatic do_op(input logic [3:0] r, input logic [63:0] av, input logic [63:0] bv,
                       input int lat, input bit nr, input logic [3:0] eg,
                       input logic [31:0] ed, input logic ee, input int ek);
    int idx;
    int k;
    bit stable;
    logic [15:0] ea, eb;
    idx = 0;
    for (int i = 0; i < N; i++) if (eg[i]) idx = i;
    ea = av[idx*16 +: 16];
    eb = bv[idx*16 +: 16];
    m_lat = lat; m_noready = nr; a_in = av; b_in = bv; req = r;
    @(negedge clk);
    check("gnt", 64'(gnt), 64'(eg));
    check("mul_start", 64'(mul_start), 64'd1);
    check("mul_a", 64'(mul_a), 64'(ea));
    check("mul_b", 64'(mul_b), 64'(eb));
    req = '0;
    @(negedge clk);
    k = 2;
    check("gnt_pulse", 64'(gnt), 64'd0);
    check("start_pulse", 64'(mul_start), 64'd0);
    stable = 1'b1;
    while (res_valid == '0 && k < 200) begin
      if (mul_a !== ea || mul_b !== eb) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    check("res_cycle", 64'(k), 64'(ek));
    check("res_valid", 64'(res_valid), 64'(eg));
    check("res_data", 64'(res_data), 64'(ed));
    check("res_err", 64'(res_err), 64'(ee));
    check("operands_held", 64'(stable), 64'd1);
    @(negedge clk);
    check("res_valid_pulse", 64'(res_valid), 64'd0);
    $display("op req=%b gnt=%b a=%h b=%h data=%h err=%b cycle=%0d", r, eg, ea, eb, res_data, ee, k);
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [15:0] a, b;
    int          lat;
    bit          nr;
    logic [3:0]  eg;
    logic [31:0] ed;
    logic        ee;
    int          ek;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ptr, w;
    logic [3:0]  r;
    logic [63:0] av, bv;
    int lat;
    bit quiet;

    rst = 1'b1; req = '0; a_in = '0; b_in = '0; busy_force = 1'b0; spur_ready = 1'b0;

    vecs[0] = '{4'b0001, 16'd300,   16'd7,     9, 1'b0, 4'b0001, 32'd2100,      1'b0, 11};
    vecs[1] = '{4'b1111, 16'hFFFF,  16'hFFFF,  4, 1'b0, 4'b0010, 32'hFFFE0001,  1'b0, 6};
    vecs[2] = '{4'b1001, 16'h1234,  16'h5678,  2, 1'b0, 4'b1000, 32'd103153760, 1'b0, 4};
    vecs[3] = '{4'b0110, 16'd0,     16'hABCD,  3, 1'b0, 4'b0010, 32'd0,         1'b0, 5};
    vecs[4] = '{4'b0101, 16'd65535, 16'd2,     5, 1'b0, 4'b0100, 32'd131070,    1'b0, 7};
    vecs[5] = '{4'b0001, 16'd100,   16'd100,   2, 1'b0, 4'b0001, 32'd10000,     1'b0, 4};
    vecs[6] = '{4'b0100, 16'd9,     16'd9,     2, 1'b1, 4'b0100, 32'd0,         1'b1, 2 + TO};
    vecs[7] = '{4'b1000, 16'd3,     16'd5,     2, 1'b0, 4'b1000, 32'd15,        1'b0, 4};

    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesting: strict rotation 0,1,2,3,0 from a reset pointer.
    for (int i = 0; i < 5; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      w  = i % N;
      do_op(4'hF, av, bv, 3, 1'b0, 4'(1 << w),
            32'(av[w*16 +: 16]) * 32'(bv[w*16 +: 16]), 1'b0, 5);
    end

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].r, {4{vecs[i].a}}, {4{vecs[i].b}}, vecs[i].lat, vecs[i].nr,
            vecs[i].eg, vecs[i].ed, vecs[i].ee, vecs[i].ek);

    // Busy multiplier blocks arbitration.
    busy_force = 1'b1;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_no_gnt", 64'(gnt), 64'd0);
    end
    busy_force = 1'b0;
    do_op(4'b0100, {4{16'd11}}, {4{16'd13}}, 3, 1'b0, 4'b0100, 32'd143, 1'b0, 5);

    // Spurious ready while idle.
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (res_valid !== '0) quiet = 1'b0;
      @(negedge clk);
    end
    check("spurious_ready", 64'(quiet), 64'd1);
    do_op(4'b0010, {4{16'd6}}, {4{16'd7}}, 2, 1'b0, 4'b0010, 32'd42, 1'b0, 4);

    // Reset in the middle of WAIT.
    m_lat = 20; m_noready = 1'b0;
    a_in = {4{16'd5}}; b_in = {4{16'd5}}; req = 4'b0001;
    @(negedge clk);
    check("pre_rst_gnt", 64'(gnt), 64'd1);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_mul_a", 64'(mul_a), 64'd0);
    check("async_rst_mul_b", 64'(mul_b), 64'd0);
    check("async_rst_outs", 64'({gnt, res_valid, res_err, mul_start, res_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (res_valid !== '0) quiet = 1'b0;
      @(negedge clk);
    end
    check("aborted_no_result", 64'(quiet), 64'd1);
    do_op(4'b1100, {4{16'd2}}, {4{16'd3}}, 2, 1'b0, 4'b0100, 32'd6, 1'b0, 4);
    do_op(4'b0010, {4{16'd4}}, {4{16'd4}}, 2, 1'b0, 4'b0010, 32'd16, 1'b0, 4);

    // Random traffic against a round-robin reference (pointer now just past requester 1).
    ptr = 2;
    for (int t = 0; t < 40; t++) begin
      r   = 4'($urandom_range(1, 15));
      av  = {$urandom, $urandom};
      bv  = {$urandom, $urandom};
      lat = $urandom_range(2, 8);
      w   = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
      do_op(r, av, bv, lat, 1'b0, 4'(1 << w),
            32'(av[w*16 +: 16]) * 32'(bv[w*16 +: 16]), 1'b0, 2 + lat);
      ptr = (w + 1) % N;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
